// File: rtl/tolva_secuenciador.sv
// Hopper batch sequencer: opens the selected dosing valves one at a time, smallest first,
// timing open and gap intervals in divider ticks, with abort, level fault and gram total.
module tolva_secuenciador #(
  parameter logic [15:0] T_OPEN = 16'd3,
  parameter logic [15:0] T_GAP  = 16'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] sel,
  input  logic       abort,
  input  logic       nivel_ok,
  output logic [3:0] valve,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [9:0] dosificado
);

  // state  | meaning
  // IDLE   | waiting for start, request mask free to be relatched
  // SCAN   | pick lowest pending valve, or finish when none remain
  // OPEN   | one valve open, counting T_OPEN ticks
  // GAP    | all valves closed, counting T_GAP ticks
  // DONE   | one-cycle completion pulse
  // ERR    | level fault latched, waits for abort
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_OPEN, S_GAP, S_DONE, S_ERR} state_t;

  localparam logic [15:0] OPEN_LAST = (T_OPEN == 16'd0) ? 16'd0 : T_OPEN - 16'd1;
  localparam logic [15:0] GAP_LAST  = (T_GAP == 16'd0) ? 16'd0 : T_GAP - 16'd1;

  state_t      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  valve_q, valve_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [9:0]  dosif_q, dosif_d;
  logic [9:0]  weight;
  logic [3:0]  low_bit;

  assign low_bit = mask_q & (~mask_q + 4'd1);
  assign weight  = (valve_q[0] ? 10'd50  : 10'd0) + (valve_q[1] ? 10'd100 : 10'd0)
                 + (valve_q[2] ? 10'd200 : 10'd0) + (valve_q[3] ? 10'd400 : 10'd0);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    valve_d = valve_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    dosif_d = dosif_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = sel;
          dosif_d = 10'd0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (mask_q == 4'd0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          valve_d = low_bit;
          cnt_d   = 16'd0;
          state_d = S_OPEN;
        end
      end
      S_OPEN: begin
        if (!nivel_ok) begin
          // partially delivered valve is not credited
          valve_d = 4'd0;
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_ERR;
        end else if (tick) begin
          if (cnt_q == OPEN_LAST) begin
            valve_d = 4'd0;
            mask_d  = mask_q & ~valve_q;
            dosif_d = dosif_q + weight;
            cnt_d   = 16'd0;
            state_d = (T_GAP == 16'd0) ? S_SCAN : S_GAP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = 16'd0;
            state_d = S_SCAN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        valve_d = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase

    // abort overrides everything but reset; the completed-valve total is kept
    if (abort) begin
      state_d = S_IDLE;
      valve_d = 4'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      error_d = 1'b0;
      cnt_d   = 16'd0;
      dosif_d = dosif_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= 4'd0;
      cnt_q   <= 16'd0;
      valve_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      dosif_q <= 10'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      valve_q <= valve_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      dosif_q <= dosif_d;
    end
  end

  assign valve      = valve_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign dosificado = dosif_q;

endmodule

// File: tb/tb_tolva_secuenciador.sv
// Self-checking bench for tolva_secuenciador: table of batch scenarios with a per-cycle
// expected-output scoreboard, plus hand sequences for reset and the fault/abort exit.
module tb_tolva_secuenciador;
  localparam int T_OPEN = 3;
  localparam int T_GAP  = 2;
  localparam int L      = 48;

  logic       clk = 1'b0;
  logic       rst, tick, start, abort, nivel_ok;
  logic [3:0] sel;
  logic [3:0] valve;
  logic       busy, done, error;
  logic [9:0] dosificado;

  tolva_secuenciador #(.T_OPEN(16'd3), .T_GAP(16'd2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .sel(sel), .abort(abort),
    .nivel_ok(nivel_ok), .valve(valve), .busy(busy), .done(done), .error(error),
    .dosificado(dosificado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valve;
    logic       busy;
    logic       done;
    logic       error;
    logic [9:0] dos;
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    int         per;
    int         abort_at;
    int         fault_at;
    int         xstart_at;
    int         exp_dos;
    int         exp_dones;
    logic       exp_err;
  } vec_t;

  exp_t ex[L];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic bit tick_at(int e, int per);
    return (per == 1) ? 1'b1 : ((e % 4) == 1);
  endfunction

  // edge index of the n-th tick strictly after edge p
  function automatic int nth_tick(int p, int n, int per);
    int c;
    int r;
    c = 0;
    r = L + 10;
    for (int e = p + 1; e < L + 10; e++) begin
      if (r == L + 10) begin
        if (tick_at(e, per)) c++;
        if (c == n) r = e;
      end
    end
    return r;
  endfunction

  task automatic fill(int a, int b, logic [3:0] v, logic bz, logic d, logic er, int dos);
    for (int k = a; k <= b; k++) begin
      if (k >= 0 && k < L) begin
        ex[k].valve = v;
        ex[k].busy  = bz;
        ex[k].done  = d;
        ex[k].error = er;
        ex[k].dos   = 10'(dos);
      end
    end
  endtask

  // sample k is taken just after edge k; edge 0 is the one that latches start
  task automatic build_expect(vec_t v);
    int pos, kf, ecl, eg, cur;
    int weights[4];
    weights = '{50, 100, 200, 400};
    cur = 0;
    kf  = 0;
    pos = 1;
    for (int b = 0; b < 4; b++) begin
      if (v.sel[b]) begin
        fill(kf, pos - 1, 4'd0, 1'b1, 1'b0, 1'b0, cur);
        ecl = nth_tick(pos, T_OPEN, v.per);
        fill(pos, ecl - 1, 4'(1 << b), 1'b1, 1'b0, 1'b0, cur);
        cur = cur + weights[b];
        kf  = ecl;
        eg  = (T_GAP > 0) ? nth_tick(ecl, T_GAP, v.per) : ecl;
        pos = eg + 1;
      end
    end
    fill(kf, pos - 1, 4'd0, 1'b1, 1'b0, 1'b0, cur);
    fill(pos, pos, 4'd0, 1'b1, 1'b1, 1'b0, cur);
    fill(pos + 1, L - 1, 4'd0, 1'b0, 1'b0, 1'b0, cur);
    if (v.abort_at > 0)
      fill(v.abort_at, L - 1, 4'd0, 1'b0, 1'b0, 1'b0, int'(ex[v.abort_at - 1].dos));
    // the level sensor only matters while a valve is open
    if (v.fault_at > 0 && ex[v.fault_at - 1].valve != 4'd0)
      fill(v.fault_at, L - 1, 4'd0, 1'b0, 1'b0, 1'b1, int'(ex[v.fault_at - 1].dos));
  endtask

  task automatic check_out(string name, exp_t e);
    n_checks++;
    if (valve !== e.valve || busy !== e.busy || done !== e.done || error !== e.error ||
        dosificado !== e.dos) begin
      n_fail++;
      $display("FAIL %s: got valve=%b busy=%b done=%b error=%b dos=%0d, want valve=%b busy=%b done=%b error=%b dos=%0d",
               name, valve, busy, done, error, dosificado, e.valve, e.busy, e.done, e.error, e.dos);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  vec_t vecs[7];
  exp_t zero_e;
  exp_t got_e;
  int   dones;
  int   multi_hot;

  initial begin
    vecs[0] = '{4'b0101, 1, -1, -1, -1, 250, 1, 1'b0};
    vecs[1] = '{4'b1111, 1, -1, -1, -1, 750, 1, 1'b0};
    vecs[2] = '{4'b0011, 1,  8, -1, -1,  50, 0, 1'b0};
    vecs[3] = '{4'b0000, 1, -1, -1, -1,   0, 1, 1'b0};
    vecs[4] = '{4'b0010, 4, -1, -1,  5, 100, 1, 1'b0};
    vecs[5] = '{4'b0011, 1, -1,  5, -1, 150, 1, 1'b0};
    vecs[6] = '{4'b1000, 1, -1,  2, -1,   0, 0, 1'b1};
    zero_e  = '{4'd0, 1'b0, 1'b0, 1'b0, 10'd0};

    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick = 1'($urandom); start = 1'($urandom); abort = 1'($urandom);
      nivel_ok = 1'($urandom); sel = 4'($urandom_range(15));
      @(posedge clk); #1;
      check_out("reset", zero_e);
    end
    rst = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0; nivel_ok = 1'b1; sel = 4'd0;
    @(posedge clk); #1;
    check_out("idle_after_reset", zero_e);

    foreach (vecs[i]) begin
      build_expect(vecs[i]);
      dones = 0;
      multi_hot = 0;
      for (int k = 0; k < L; k++) begin
        start    = (k == 0 || k == vecs[i].xstart_at);
        sel      = (k == 0) ? vecs[i].sel : 4'($urandom_range(15));
        tick     = tick_at(k, vecs[i].per);
        abort    = (k == vecs[i].abort_at);
        nivel_ok = (k != vecs[i].fault_at);
        sb_q.push_back(ex[k]);
        @(posedge clk); #1;
        got_e = sb_q.pop_front();
        check_out($sformatf("row%0d_cyc%0d", i, k), got_e);
        if (done) dones++;
        if ($countones(valve) > 1) multi_hot++;
      end
      start = 1'b0; abort = 1'b0; nivel_ok = 1'b1;
      check_int($sformatf("row%0d_dosificado", i), int'(dosificado), vecs[i].exp_dos);
      check_int($sformatf("row%0d_done_count", i), dones, vecs[i].exp_dones);
      check_int($sformatf("row%0d_error", i), int'(error), int'(vecs[i].exp_err));
      check_int($sformatf("row%0d_multi_hot", i), multi_hot, 0);
    end

    // fault state: start is ignored, abort returns to IDLE and clears error
    start = 1'b1; sel = 4'hF; tick = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_out("err_start_ignored", '{4'd0, 1'b0, 1'b0, 1'b1, 10'd0});
    @(posedge clk); #1;
    check_out("err_holds", '{4'd0, 1'b0, 1'b0, 1'b1, 10'd0});
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_out("err_abort", zero_e);
    @(posedge clk); #1;
    check_out("idle_after_abort", zero_e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
